// File: rtl/sbp_pkg.sv
// sbp_pkg: shared constants, FSM states and latency helper for the lookup scheduler
package sbp_pkg;
    localparam int SBP_STAGE_NONE = 0;
    localparam int SBP_STAGE_ROOT = 1;
    typedef enum logic {RUN, BATCH} sbp_state_e;
    function automatic int sbp_lat(input int num_stages);
        return 2 * num_stages;
    endfunction
endpackage

// File: rtl/sbp_delay_line.sv
// sbp_delay_line: fixed-depth shift register; reset clears only the valid (MSB) bit
module sbp_delay_line #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] line [DEPTH];
    always_ff @(posedge clk) begin
        line[0] <= d;
        for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        if (rst) for (int i = 0; i < DEPTH; i++) line[i][WIDTH-1] <= 1'b0;
    end
    assign q = line[DEPTH-1];
endmodule

// File: rtl/sbp_lookup_scheduler.sv
// sbp_lookup_scheduler: shares the pipeline head between lookups and atomic update batches
module sbp_lookup_scheduler
    import sbp_pkg::*;
#(
    parameter int STAGE_ID_BITS    = 6,
    parameter int LOCATION_BITS    = 11,
    parameter int RESULT_BITS      = 24,
    parameter int NUM_STAGES       = 32,
    parameter int TAG_BITS         = 4,
    parameter int MAX_LOOKUP_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lk_valid_i,
    output logic                     lk_ready_o,
    input  logic [31:0]              lk_ip_addr_i,
    input  logic [TAG_BITS-1:0]      lk_tag_i,
    input  logic                     up_valid_i,
    output logic                     up_ready_o,
    input  logic [31:0]              up_prefix_i,
    input  logic [5:0]               up_prefix_len_i,
    input  logic [STAGE_ID_BITS-1:0] up_stage_id_i,
    input  logic [LOCATION_BITS-1:0] up_location_i,
    input  logic [RESULT_BITS-1:0]   up_result_i,
    input  logic                     up_last_i,
    output logic                     update_o,
    output logic [31:0]              ip_addr_o,
    output logic [5:0]               bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    input  logic [RESULT_BITS-1:0]   tail_result_i,
    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_ip_addr_o,
    output logic [TAG_BITS-1:0]      rsp_tag_o,
    output logic [RESULT_BITS-1:0]   rsp_result_o,
    output logic                     idle_o
);
    localparam int LAT        = sbp_lat(NUM_STAGES);
    localparam int BURST_BITS = $clog2(MAX_LOOKUP_BURST + 1);
    localparam int INFL_BITS  = $clog2(LAT + 2);
    localparam int DL_WIDTH   = 1 + TAG_BITS + 32;

    sbp_state_e            state;
    logic [BURST_BITS-1:0] burst_cnt;
    logic [INFL_BITS-1:0]  inflight_cnt;
    logic                  burst_full, lk_grant, up_grant, head_lookup, retire;
    logic [TAG_BITS-1:0]   head_tag, tail_tag;
    logic [31:0]           tail_addr;

    assign burst_full = burst_cnt == BURST_BITS'(MAX_LOOKUP_BURST);
    // A waiting update only overtakes lookups once the burst allowance is used up
    assign lk_ready_o = !rst && state == RUN && !(up_valid_i && burst_full);
    assign up_ready_o = !rst && (state == BATCH || !lk_valid_i || burst_full);
    assign lk_grant   = lk_valid_i && lk_ready_o;
    assign up_grant   = up_valid_i && up_ready_o;
    assign idle_o     = inflight_cnt == '0 && state == RUN && !lk_grant && !up_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            burst_cnt     <= '0;
            inflight_cnt  <= '0;
            update_o      <= 1'b0;
            ip_addr_o     <= '0;
            bit_pos_o     <= '0;
            stage_id_o    <= '0;
            location_o    <= '0;
            result_o      <= '0;
            head_lookup   <= 1'b0;
            head_tag      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_ip_addr_o <= '0;
            rsp_tag_o     <= '0;
            rsp_result_o  <= '0;
        end else begin
            if (up_grant) state <= up_last_i ? RUN : BATCH;
            burst_cnt    <= (!up_valid_i || up_grant) ? '0 :
                            (lk_grant && !burst_full) ? burst_cnt + 1'b1 : burst_cnt;
            inflight_cnt <= inflight_cnt + INFL_BITS'(lk_grant) - INFL_BITS'(retire);
            update_o     <= up_grant;
            ip_addr_o    <= up_grant ? up_prefix_i : lk_grant ? lk_ip_addr_i : '0;
            bit_pos_o    <= up_grant ? up_prefix_len_i : '0;
            stage_id_o   <= up_grant ? up_stage_id_i :
                            lk_grant ? STAGE_ID_BITS'(SBP_STAGE_ROOT) : STAGE_ID_BITS'(SBP_STAGE_NONE);
            location_o   <= up_grant ? up_location_i : '0;
            result_o     <= up_grant ? up_result_i : '0;
            head_lookup  <= lk_grant;
            head_tag     <= lk_grant ? lk_tag_i : '0;
            rsp_valid_o   <= retire;
            rsp_ip_addr_o <= tail_addr;
            rsp_tag_o     <= tail_tag;
            rsp_result_o  <= tail_result_i;
        end
    end

    // Fed from the head registers so its output lines up with tail_result_i
    sbp_delay_line #(.WIDTH(DL_WIDTH), .DEPTH(LAT)) u_tags (
        .clk (clk),
        .rst (rst),
        .d   ({head_lookup, head_tag, ip_addr_o}),
        .q   ({retire, tail_tag, tail_addr})
    );
endmodule
